// File: rtl/adc_player_pkg.sv
// Shared mode/state encodings and sizing helper for the ADC pattern player.
package adc_player_pkg;

  typedef enum logic [1:0] {
    ModeCont   = 2'd0,
    ModeBurst  = 2'd1,
    ModeSingle = 2'd2,
    ModeHold   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGap  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Bits needed to count 0..n-1, never fewer than min_w.
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned min_w);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w > min_w) ? w : min_w;
  endfunction

endpackage

// File: rtl/pattern_ram.sv
// Pattern storage: one write port with per-channel byte-lane style mask, one registered read.
module pattern_ram #(
  parameter int unsigned Words = 150,
  parameter int unsigned AW    = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned ChW   = 12,
  localparam int unsigned DW   = NCH * ChW
) (
  input  logic           clk_adc,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [NCH-1:0] wr_be,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data
);

  logic [DW-1:0] mem_q [Words];
  logic [DW-1:0] rd_data_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_adc) begin
    if (wr_en) begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (wr_be[k]) begin
          mem_q[wr_addr][k*ChW +: ChW] <= wr_data[k*ChW +: ChW];
        end
      end
    end
  end

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_pattern_player.sv
// Plays a stored multi-channel sample pattern, one sample per external ADC clock edge.
module adc_pattern_player
  import adc_player_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned ADCBITS   = 12,
  parameter int unsigned AW        = 10,
  parameter int unsigned LAST_ADDR = 149,
  parameter int unsigned GAP       = 70000,
  parameter int unsigned BURST     = 15,
  localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_adc,
  input  logic                   reset,
  input  logic                   adc_clk_in,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   wr_en,
  input  logic [CW-1:0]          wr_ch,
  input  logic [AW-1:0]          wr_addr,
  input  logic [ADCBITS-1:0]     wr_data,
  output logic [NCH*ADCBITS-1:0] ch_data,
  output logic                   sample_stb,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DW = NCH * ADCBITS;
  localparam int unsigned IW = cnt_width(LAST_ADDR + 1, 1);
  localparam int unsigned GW = cnt_width(GAP, 17);
  localparam int unsigned BW = cnt_width(BURST, 1);

  logic sync1_q, sync2_q, prev_q, tick;

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           rd_en_q, rd_en_d;
  logic [IW-1:0]  rd_addr_q, rd_addr_d;
  logic           sample_stb_q, sample_stb_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           wr_ok;
  logic [NCH-1:0] wr_be;

  assign tick = sync2_q & ~prev_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    gap_cnt_d    = gap_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mode_d      = mode_e'(mode);
          addr_d      = '0;
          gap_cnt_d   = '0;
          burst_cnt_d = '0;
          unique case (mode_e'(mode))
            ModeCont, ModeSingle: state_d = StRun;
            ModeBurst:            state_d = StGap;
            default:              state_d = StIdle;
          endcase
        end
      end
      StGap: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d     = StRun;
          burst_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (tick) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q[IW-1:0];
          addr_d    = (addr_q == AW'(LAST_ADDR)) ? '0 : addr_q + 1'b1;
          if (mode_q == ModeBurst) begin
            if (burst_cnt_q == BW'(BURST - 1)) begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end else begin
              burst_cnt_d = burst_cnt_q + 1'b1;
            end
          end else if (mode_q == ModeSingle && addr_q == AW'(LAST_ADDR)) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // stop outranks start and also cancels any read still in flight
    if (stop) begin
      state_d = StIdle;
      rd_en_d = 1'b0;
    end

    sample_stb_d = rd_en_q & ~stop;
    busy_d       = (state_d == StGap) || (state_d == StRun);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      state_q      <= StIdle;
      mode_q       <= ModeCont;
      addr_q       <= '0;
      gap_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      sample_stb_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sync1_q      <= adc_clk_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      gap_cnt_q    <= gap_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      sample_stb_q <= sample_stb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign wr_ok = wr_en && (wr_addr <= AW'(LAST_ADDR));
  assign wr_be = wr_ok ? NCH'(1) << wr_ch : '0;

  pattern_ram #(
    .Words (LAST_ADDR + 1),
    .AW    (IW),
    .NCH   (NCH),
    .ChW   (ADCBITS)
  ) u_pattern_ram (
    .clk_adc (clk_adc),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_be   (wr_be),
    .wr_addr (wr_addr[IW-1:0]),
    .wr_data ({NCH{wr_data}}),
    .rd_en   (rd_en_q & ~stop),
    .rd_addr (rd_addr_q),
    .rd_data (ch_data)
  );

  assign sample_stb = sample_stb_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_adc_pattern_player.sv
// Scoreboard bench for adc_pattern_player: expected samples queued at stimulus, checked on strobe.
module tb_adc_pattern_player;

  localparam int unsigned AW   = 10;
  localparam int          LAST = 149;

  logic          clk_adc = 1'b0;
  logic          reset, adc_clk_in, start, stop, wr_en;
  logic [1:0]    mode;
  logic [0:0]    wr_ch;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [23:0]   ch_data;
  logic          sample_stb, busy, done;

  always #5 clk_adc = ~clk_adc;

  adc_pattern_player #(
    .NCH       (2),
    .ADCBITS   (12),
    .AW        (AW),
    .LAST_ADDR (LAST),
    .GAP       (100),
    .BURST     (15)
  ) dut (
    .clk_adc    (clk_adc),
    .reset      (reset),
    .adc_clk_in (adc_clk_in),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ch_data    (ch_data),
    .sample_stb (sample_stb),
    .busy       (busy),
    .done       (done)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          stb_cnt = 0;
  int          first_rise = -1;
  int          stb_cyc[$];
  bit          tick_en = 1'b0;
  bit          prev_stb = 1'b0;
  logic [11:0] mem_m [2][LAST+1];
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_of(input int a);
    return {mem_m[1][a], mem_m[0][a]};
  endfunction

  always @(posedge clk_adc) cyc <= cyc + 1;

  // External sample clock: period of 4 clk_adc cycles while enabled.
  initial begin
    adc_clk_in = 1'b0;
    forever begin
      repeat (2) @(negedge clk_adc);
      if (tick_en) begin
        adc_clk_in = ~adc_clk_in;
        if (adc_clk_in && first_rise < 0) first_rise = cyc;
      end else begin
        adc_clk_in = 1'b0;
      end
    end
  end

  always @(negedge clk_adc) begin
    if (sample_stb) begin
      stb_cnt++;
      stb_cyc.push_back(cyc);
      check("stb_width", 32'(prev_stb), 32'(0));
      if (exp_q.size() == 0) check("stb_unexpected", 32'(sample_stb), 32'(0));
      else                   check("ch_data", 32'(ch_data), 32'(exp_q.pop_front()));
    end
    prev_stb = sample_stb;
  end

  task automatic wr(input int ch, input int a, input logic [11:0] d);
    @(negedge clk_adc);
    wr_en = 1'b1; wr_ch = 1'(ch); wr_addr = AW'(a); wr_data = d;
    if (a <= LAST) mem_m[ch][a] = d;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk_adc);
    mode = m; start = 1'b1;
    @(negedge clk_adc);
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    @(negedge clk_adc);
    stop = 1'b1;
    @(negedge clk_adc);
    stop = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (stb_cnt < n && k < budget) begin
      @(posedge clk_adc);
      k++;
    end
    check(tag, 32'(stb_cnt), 32'(n));
  endtask

  task automatic new_run(input int n);
    stb_cnt = 0;
    stb_cyc.delete();
    first_rise = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(exp_of(i % (LAST + 1)));
  endtask

  initial begin
    int lat, gap, k;
    bit found;
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk_adc);
    check("rst_ch_data", 32'(ch_data), 32'(0));
    check("rst_stb", 32'(sample_stb), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    reset = 1'b0;

    for (int a = 0; a <= LAST; a++) begin
      wr(0, a, 12'(a));
      wr(1, a, 12'h800 + 12'(a));
    end
    wr(0, 200, 12'h5A5);
    @(negedge clk_adc);
    wr_en = 1'b0;

    // Continuous: 160 samples wrap after 149; collision write on address 5 in pass one.
    new_run(160);
    exp_q[155] = {12'hABC, mem_m[0][5]};
    pulse_start(2'd0);
    mode = 2'd2;
    tick_en = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      @(negedge clk_adc);
      k++;
      if (sample_stb && ch_data[11:0] == 12'd4) found = 1'b1;
    end
    check("find_addr4", 32'(found), 32'(1));
    check("cont_busy", 32'(busy), 32'(1));
    repeat (3) @(negedge clk_adc);
    wr_en = 1'b1; wr_ch = 1'b1; wr_addr = AW'(5); wr_data = 12'hABC;
    mem_m[1][5] = 12'hABC;
    @(negedge clk_adc);
    wr_en = 1'b0;
    wait_stb("cont_cnt", 160, 2000);
    pulse_stop;
    repeat (20) @(negedge clk_adc);
    check("cont_total", 32'(stb_cnt), 32'(160));
    check("cont_drain", 32'(exp_q.size()), 32'(0));
    lat = stb_cyc[0] - first_rise;
    check("first_latency", 32'(lat >= 2 && lat <= 5), 32'(1));

    // Burst: 15 samples, gap of 100 cycles, then addresses 15..29.
    new_run(30);
    pulse_start(2'd1);
    wait_stb("burst_cnt", 30, 1500);
    pulse_stop;
    repeat (10) @(negedge clk_adc);
    check("burst_spacing", 32'(stb_cyc[1] - stb_cyc[0]), 32'(4));
    gap = stb_cyc[15] - stb_cyc[14];
    check("burst_gap", 32'(gap >= 101 && gap <= 104), 32'(1));
    check("burst2_span", 32'(stb_cyc[29] - stb_cyc[15]), 32'(56));
    check("burst_drain", 32'(exp_q.size()), 32'(0));

    // Single pass, then replay from DONE.
    new_run(LAST + 1);
    pulse_start(2'd2);
    wait_stb("single_cnt", LAST + 1, 1500);
    repeat (250) @(negedge clk_adc);
    check("single_total", 32'(stb_cnt), 32'(LAST + 1));
    check("single_done", 32'(done), 32'(1));
    check("single_busy", 32'(busy), 32'(0));
    new_run(LAST + 1);
    pulse_start(2'd2);
    wait_stb("single2_cnt", LAST + 1, 1500);
    repeat (10) @(negedge clk_adc);
    check("single2_done", 32'(done), 32'(1));
    check("single2_drain", 32'(exp_q.size()), 32'(0));

    // Stop at address 37; then start+stop together; then HOLD.
    new_run(38);
    pulse_start(2'd0);
    wait_stb("stop37_cnt", 38, 500);
    pulse_stop;
    check("stop_busy", 32'(busy), 32'(0));
    repeat (30) @(negedge clk_adc);
    check("stop37_total", 32'(stb_cnt), 32'(38));
    check("stop37_hold", 32'(ch_data), 32'(exp_of(37)));
    @(negedge clk_adc);
    mode = 2'd0; start = 1'b1; stop = 1'b1;
    @(negedge clk_adc);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'(0));
    repeat (40) @(negedge clk_adc);
    check("startstop_stb", 32'(stb_cnt), 32'(38));
    pulse_start(2'd3);
    repeat (40) @(negedge clk_adc);
    check("hold_busy", 32'(busy), 32'(0));
    check("hold_stb", 32'(stb_cnt), 32'(38));
    check("hold_data", 32'(ch_data), 32'(exp_of(37)));

    // Reset mid-burst, then confirm memory survived.
    new_run(5);
    pulse_start(2'd1);
    wait_stb("rst_pre_cnt", 5, 800);
    @(negedge clk_adc);
    reset = 1'b1;
    @(negedge clk_adc);
    check("midrst_ch_data", 32'(ch_data), 32'(0));
    check("midrst_stb", 32'(sample_stb), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    reset = 1'b0;
    repeat (40) @(negedge clk_adc);
    check("midrst_no_stb", 32'(stb_cnt), 32'(5));
    new_run(10);
    pulse_start(2'd0);
    wait_stb("after_rst_cnt", 10, 300);
    pulse_stop;
    repeat (10) @(negedge clk_adc);
    check("after_rst_drain", 32'(exp_q.size()), 32'(0));

    tick_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/adc_pattern_player.md
ADC_PATTERN_PLAYER -- requirements
Module: adc_pattern_player

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NCH, 2, number of channels.
- ADCBITS, 12, bits per sample.
- AW, 10, pattern address width.
- LAST_ADDR, 149, final pattern address before wrap.
- GAP, 70000, burst-mode gap length in clk_adc cycles.
- BURST, 15, samples per burst.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk_adc, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- adc_clk_in, in, 1, asynchronous external sample clock.
- mode, in, 2, playback mode.
- start, in, 1, begin playback (pulse).
- stop, in, 1, abort to IDLE (pulse).
- wr_en, in, 1, pattern write strobe.
- wr_ch, in, clog2(NCH), channel to write.
- wr_addr, in, AW, pattern address to write.
- wr_data, in, ADCBITS, pattern sample to write.
- ch_data, out, NCH*ADCBITS, channel k at bits [k*ADCBITS +: ADCBITS].
- sample_stb, out, 1, new sample presented.
- busy, out, 1, FSM not IDLE/DONE.
- done, out, 1, single-shot pass finished.
REQ-003 Reset SHALL be reset, synchronous, active-high; the clock SHALL be clk_adc; all logic SHALL be in the clk_adc domain.

Function
REQ-004 adc_clk_in SHALL pass a 2-flop synchronizer, then a rising-edge detector producing a one-cycle tick; the first tick SHALL appear at most 3 cycles after the input rises.
REQ-005 Mode encoding SHALL be:
- 0 CONT: loop forever.
- 1 BURST: GAP cycles, then BURST samples, repeat.
- 2 SINGLE: one pass over addresses 0..LAST_ADDR.
- 3 HOLD: ch_data frozen, no advance.
REQ-006 FSM states SHALL be IDLE, GAP, RUN, DONE.
REQ-007 From IDLE, start SHALL latch mode and enter one state:
- CONT or SINGLE enters RUN.
- BURST enters GAP.
- HOLD stays in IDLE.
REQ-008 The address SHALL clear to 0 on every IDLE exit.
REQ-009 In RUN, each tick SHALL advance the address.
- At LAST_ADDR the next address SHALL be 0.
- Addresses SHALL never exceed LAST_ADDR.
REQ-010 In GAP, a 17-bit-minimum counter SHALL count GAP cycles from 0; on reaching GAP-1 the FSM SHALL enter RUN and clear the burst counter. Ticks in GAP SHALL be ignored.
REQ-011 In BURST RUN, a burst counter SHALL count ticks.
- On the BURST-th tick the FSM SHALL return to GAP.
- The address SHALL persist across bursts and wrap per REQ-009.
REQ-012 In SINGLE RUN, the tick at address LAST_ADDR SHALL emit that sample and then enter DONE.
- done SHALL be high in DONE.
- busy SHALL be low in DONE.
- DONE SHALL return to IDLE on start, which also restarts playback, or on stop.
REQ-013 stop SHALL force IDLE from any state within one cycle; ch_data SHALL hold its last value.
REQ-014 If start and stop are both high in the same cycle, stop SHALL win.
REQ-015 Read latency: for a tick in cycle T, the read SHALL occur in T+1 and ch_data and sample_stb SHALL update in T+2.
- sample_stb SHALL be high for exactly one cycle per sample.
- All NCH channels SHALL update in the same cycle.
REQ-016 The pattern memory SHALL have NCH x (LAST_ADDR+1) words.
- Writes SHALL be accepted in any state.
- A same-cycle write and read to one address SHALL return the old data.
- A write with wr_addr > LAST_ADDR SHALL be ignored.
REQ-017 mode changes after start SHALL have no effect until the next start.

Reset
REQ-018 On reset:
- FSM SHALL go to IDLE.
- Address, gap counter, burst counter and synchronizer flops SHALL be 0.
- ch_data, sample_stb, busy and done SHALL be 0.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 Reset asserted mid-burst SHALL take effect on the next clk_adc edge, with no sample_stb afterwards.

Structure
REQ-021 Mode constants and the state enum SHALL live in shared package adc_player_pkg.
REQ-022 Pattern storage SHALL be a separate sub-module pattern_ram: one write port, one registered read port, width NCH*ADCBITS, with a per-channel write-enable mask.

Verification
REQ-023 CONT, LAST_ADDR=149, ramp pattern, 160 ticks -> samples 0..149 then 0..9; exactly 160 strobes.
REQ-024 BURST, GAP=100, BURST=15 -> 15 strobes, then no strobes for 100 cycles, then the next 15 samples continue from address 15.
REQ-025 SINGLE with 200 ticks -> exactly 150 strobes, done=1 after the last, busy=0; a second start replays from address 0.
REQ-026 stop at address 37 -> IDLE next cycle, ch_data holds sample 37, no further strobes; start and stop in the same cycle -> remains IDLE.
REQ-027 Write channel 1 addr 5 = 0xABC while address 5 is being read -> old value this pass, 0xABC on the next pass; write to addr 200 is ignored.
REQ-028 Reset asserted mid-burst -> all outputs 0 the next cycle; memory pattern intact after restart.
